// File: rtl/sampler_pkg.sv
// Shared types, RGB channel slices and the window hit test for sticker_sampler.
package sampler_pkg;

  typedef logic [29:0] color_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    ACCUM,
    EMIT,
    DONE
  } sampler_state_t;

  localparam int R_MSB = 29;
  localparam int R_LSB = 20;
  localparam int G_MSB = 19;
  localparam int G_LSB = 10;
  localparam int B_MSB = 9;
  localparam int B_LSB = 0;

  // True when coord lies in [origin + idx*pitch, origin + idx*pitch + win).
  // Evaluated at 16 bits so windows near the 12-bit edge never wrap.
  function automatic logic win_hit(input logic [11:0] coord,
                                   input logic [11:0] origin,
                                   input logic [1:0]  idx,
                                   input logic [11:0] pitch,
                                   input logic [11:0] win);
    logic [15:0] lo;
    lo = {4'd0, origin} + ({14'd0, idx} * {4'd0, pitch});
    return ({4'd0, coord} >= lo) && ({4'd0, coord} < (lo + {4'd0, win}));
  endfunction

endpackage

// File: rtl/sticker_sampler_window_accum.sv
// One window column's R/G/B sum registers; avg is the sum shifted down by the window area.
module window_accum
  import sampler_pkg::*;
#(
  parameter int WIN_LOG2 = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   add,
  input  color_t pix,
  output color_t avg
);

  localparam int AW = 10 + 2 * WIN_LOG2;

  logic [AW-1:0] r_q, g_q, b_q;
  logic [AW-1:0] r_d, g_d, b_d;

  // clr and add together load the new pixel, so a frame restart keeps its first pixel.
  always_comb begin
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (clr) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end
    if (add) begin
      r_d = r_d + AW'(pix[R_MSB:R_LSB]);
      g_d = g_d + AW'(pix[G_MSB:G_LSB]);
      b_d = b_d + AW'(pix[B_MSB:B_LSB]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign avg = {10'(r_q >> (2 * WIN_LOG2)),
                10'(g_q >> (2 * WIN_LOG2)),
                10'(b_q >> (2 * WIN_LOG2))};

endmodule

// File: rtl/sticker_sampler.sv
// Averages a 3x3 grid of square pixel windows into nine sticker colours per face capture.
// Optional STICKER_SAMPLER_OVERLAY_EN adds the registered In_window flag for box drawing.
module sticker_sampler
  import sampler_pkg::*;
#(
  parameter logic [11:0] X0       = 12'd200,
  parameter logic [11:0] Y0       = 12'd120,
  parameter logic [11:0] PITCH    = 12'd80,
  parameter int          WIN_LOG2 = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Pix_valid,
  input  logic [11:0] X_cont,
  input  logic [11:0] Y_cont,
  input  logic [29:0] Pix_in,
  output logic [29:0] Color_out,
  output logic        Color_valid,
  output logic [3:0]  Sticker_idx,
  output logic        Busy,
`ifdef STICKER_SAMPLER_OVERLAY_EN
  output logic        In_window,
`endif
  output logic        Done
);

  localparam logic [11:0] WIN    = 12'(1 << WIN_LOG2);
  localparam logic [11:0] X_LAST = X0 + 12'd2 * PITCH + WIN - 12'd1;

  sampler_state_t state_q, state_d;
  logic [1:0]  row_q, row_d;
  logic [1:0]  emit_cnt_q, emit_cnt_d;
  color_t      color_q, color_d;
  logic        valid_q, valid_d;
  logic [3:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        frame_start, restart, accept, last_px, y_hit, acc_clr;
  logic [1:0]  row_eff;
  logic [11:0] y_last;
  logic [2:0]  x_hit, acc_add;
  color_t      avg [3];

  // A restarting frame is judged against row 0 even though row_q has not reset yet.
  always_comb begin
    frame_start = Pix_valid && (X_cont == 12'd0) && (Y_cont == 12'd0);
    restart     = frame_start &&
                  ((state_q == ARMED) || (state_q == ACCUM) || (state_q == EMIT));
    row_eff     = restart ? 2'd0 : row_q;
    y_hit       = win_hit(Y_cont, Y0, row_eff, PITCH, WIN);
    for (int c = 0; c < 3; c++) begin
      x_hit[c] = win_hit(X_cont, X0, 2'(c), PITCH, WIN);
    end
    y_last  = Y0 + {10'd0, row_eff} * PITCH + WIN - 12'd1;
    last_px = Pix_valid && (X_cont == X_LAST) && (Y_cont == y_last);
    accept  = Pix_valid && ((state_q == ACCUM) || restart);
    for (int c = 0; c < 3; c++) begin
      acc_add[c] = accept && y_hit && x_hit[c];
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_col
    window_accum #(
      .WIN_LOG2(WIN_LOG2)
    ) u_accum (
      .clk(Clk),
      .rst(Reset),
      .clr(acc_clr),
      .add(acc_add[c]),
      .pix(Pix_in),
      .avg(avg[c])
    );
  end

  // Col 0 and col 1 windows close earlier on the same line, so their sums are final
  // when the col 2 last pixel arrives; col 2 is read two cycles later.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    emit_cnt_d = emit_cnt_q;
    color_d    = color_q;
    valid_d    = 1'b0;
    idx_d      = idx_q;
    done_d     = 1'b0;
    acc_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start) state_d = ARMED;
      end
      ARMED: begin
        if (restart) begin
          acc_clr = 1'b1;
          row_d   = 2'd0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (restart) begin
          acc_clr = 1'b1;
          row_d   = 2'd0;
        end else if (last_px) begin
          state_d    = EMIT;
          emit_cnt_d = 2'd1;
          valid_d    = 1'b1;
          color_d    = avg[0];
          idx_d      = {2'b00, row_q} * 4'd3;
        end
      end
      EMIT: begin
        if (restart) begin
          acc_clr = 1'b1;
          row_d   = 2'd0;
          state_d = ACCUM;
        end else if (emit_cnt_q == 2'd3) begin
          acc_clr = 1'b1;
          if (row_q == 2'd2) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            row_d   = row_q + 2'd1;
            state_d = ACCUM;
          end
        end else begin
          valid_d    = 1'b1;
          color_d    = (emit_cnt_q == 2'd1) ? avg[1] : avg[2];
          idx_d      = idx_q + 4'd1;
          emit_cnt_d = emit_cnt_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= IDLE;
      row_q      <= 2'd0;
      emit_cnt_q <= 2'd0;
      color_q    <= '0;
      valid_q    <= 1'b0;
      idx_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      emit_cnt_q <= emit_cnt_d;
      color_q    <= color_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Color_out   = color_q;
  assign Color_valid = valid_q;
  assign Sticker_idx = idx_q;
  assign Busy        = busy_q;
  assign Done        = done_q;

`ifdef STICKER_SAMPLER_OVERLAY_EN
  logic in_window_q, in_window_d;
  logic any_x, any_y;

  always_comb begin
    any_x = 1'b0;
    any_y = 1'b0;
    for (int i = 0; i < 3; i++) begin
      any_x = any_x | win_hit(X_cont, X0, 2'(i), PITCH, WIN);
      any_y = any_y | win_hit(Y_cont, Y0, 2'(i), PITCH, WIN);
    end
    in_window_d = (state_q != IDLE) && Pix_valid && any_x && any_y;
  end

  always_ff @(posedge Clk) begin
    if (Reset) in_window_q <= 1'b0;
    else       in_window_q <= in_window_d;
  end

  assign In_window = in_window_q;
`endif

endmodule

// File: doc/sticker_sampler.md
# sticker_sampler

Averages the camera pixel stream over a 3x3 grid of square sample windows, one window per cube sticker, and emits one 30-bit mean colour per sticker. It sits directly upstream of the colour classifier. Color_out and Color_valid drive the classifier's colour input and check-enable. One Start request captures one full face: nine averaged colours in raster order, then Done.

## Interface
Parameters:
- X0, 12'd200: left edge (pixel column) of window column 0.
- Y0, 12'd120: top edge (pixel line) of window row 0.
- PITCH, 12'd80: distance between window origins, both axes; must satisfy PITCH ≥ WIN+2.
- WIN_LOG2, 3: window side = WIN = 2^WIN_LOG2 pixels (legal 1..5).

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: synchronous, active-high.
- Start, in, 1: request one face capture; sampled only in IDLE.
- Pix_valid, in, 1: pixel qualifier (CCD DVAL).
- X_cont, in, 12: current pixel column.
- Y_cont, in, 12: current pixel line.
- Pix_in, in, 30: pixel {R[29:20], G[19:10], B[9:0]}.
- Color_out, out, 30: averaged sticker colour.
- Color_valid, out, 1: one-cycle strobe per sticker; feeds classifier cc.
- Sticker_idx, out, 4: row*3+col of the current Color_out, 0..8.
- Busy, out, 1: high in every state except IDLE.
- Done, out, 1: one-cycle pulse after the 9th sticker is emitted.

## Operation
- States:
  - IDLE: Start → ARMED.
  - ARMED: waits for Pix_valid with X_cont=0 and Y_cont=0, which guarantees a whole frame. On that pixel: clear accumulators, set row=0, go to ACCUM, and process the pixel.
  - ACCUM: on a valid pixel inside window (row, col), add R, G and B to column col's accumulators. The window spans X0+col*PITCH ≤ X < X0+col*PITCH+WIN and Y0+row*PITCH ≤ Y < Y0+row*PITCH+WIN. The last pixel of window (row, 2) → EMIT.
  - EMIT: 3 cycles. Each cycle outputs the col 0, 1, 2 average in turn. Afterwards, clear the accumulators. If row<2: row++ and → ACCUM. If row=2: → DONE.
  - DONE: pulse Done for 1 cycle, then → IDLE.
- Accumulator width per channel: 10+2*WIN_LOG2 bits, unsigned, cannot overflow.
- Average = sum >> 2*WIN_LOG2, i.e. floor truncation with no rounding.
- Pixels with Pix_valid=0 are ignored in every state.
- Pixels arriving during EMIT are ignored. The PITCH rule guarantees they fall outside all windows.
- Start while Busy is ignored.
- A pixel at (0,0) seen in ACCUM or EMIT is a premature frame restart. Abort the capture: clear the accumulators, set row=0, stay in/return to ACCUM, and accumulate that pixel. Do not emit a partial face.
- Reset in any state: go to IDLE, clear the accumulators, and drive all outputs to 0 (Color_out=0, Color_valid=0, Sticker_idx=0, Busy=0, Done=0).

## Timing
- All outputs are registered.
- The last pixel of window (row, 2) is accepted at cycle N. Color_valid is high for cycles N+1, N+2 and N+3, with Sticker_idx = 3*row, 3*row+1, 3*row+2.
- Done is high at cycle N+4 of row 2. Busy falls at N+5.
- Between strobes, Color_out holds its last value; Sticker_idx holds as well.
- Start accepted at cycle T gives Busy=1 at T+1.

## Configuration
- STICKER_SAMPLER_OVERLAY_EN:
  - Defined: adds output port In_window (1 bit). It is a registered flag, high one cycle after a valid pixel inside any of the 9 windows, in every state except IDLE. The VGA path uses it to draw the sampling boxes. It resets to 0.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package sampler_pkg holds:
  - typedef color_t (logic [29:0]);
  - enum sampler_state_t {IDLE, ARMED, ACCUM, EMIT, DONE};
  - channel slice localparams R_MSB/R_LSB/G_MSB/G_LSB/B_MSB/B_LSB;
  - function win_hit(coord, origin, idx, pitch, win).
- Sub-module window_accum: per-column RGB accumulators with clear/add inputs and an averaged color_t output. Instantiate 3 times.
- The top level owns the FSM, the row counter and the output registers.

## Test plan
- Uniform frame, Pix_in=30'h3FF00000 (red), Start: 9 strobes, all Color_out=30'h3FF00000, Sticker_idx 0..8 in order, then Done one cycle after idx 8.
- WIN_LOG2=1, window (0,0) G channel pixels 0,1,2,3 with all other pixels 0: idx 0 output G=1 (floor 6/4), R=B=0.
- Start issued mid-frame (Y=50): no accumulation until the next (0,0); the first strobe appears in the following frame.
- Pix_valid toggled low every other cycle across windows: averages identical to the gap-free run.
- Reset asserted during EMIT of row 1: next cycle all outputs 0, state IDLE; a following Start captures a full clean face.
- Premature (0,0) after row 0 emitted: no Done, row restarts at 0, idx 0..8 emitted afresh.
